// File: rtl/mul_acc_stage.sv
// =============================================================================
// mul_acc_stage
// -----------------------------------------------------------------------------
// Accumulator stage placed directly after the 3x3 array multiplier. It sums a
// packet of 6-bit unsigned products, giving the dot product of two 3-bit
// vectors. A packet closes when the producer flags in_last, or automatically
// once MAX_TERMS products have been accepted. The finished result is then held
// on a valid/ready output until downstream takes it.
//
// Parameters
//   ACC_W      accumulator / result width in bits (>= 6)
//   MAX_TERMS  products per packet before auto-close (1..255)
//
// Optional feature (compile-time macro)
//   SATURATE_EN  defined   : on carry out of the accumulator, acc_out clamps
//                            to 2^ACC_W-1 and stays there for the rest of the
//                            packet; overflow is set.
//                undefined : acc_out wraps modulo 2^ACC_W; overflow is set
//                            and stays set until the result handshake.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      prod / in_last are valid
//   in_ready   out  1      stage accepts a product this cycle
//   prod       in   6      unsigned product from the multiplier
//   in_last    in   1      this product closes the packet
//   out_valid  out  1      acc_out / n_terms / overflow hold a finished result
//   out_ready  in   1      downstream takes the result
//   acc_out    out  ACC_W  packet sum (running sum while accumulating)
//   n_terms    out  8      number of products in the packet
//   overflow   out  1      sum exceeded 2^ACC_W-1 at some point in the packet
//
// Timing
//   in_ready and out_valid are decoded from the state register only, so
//   neither handshake has a combinational path through this stage. The result
//   appears one cycle after the closing accept. The cycle in which the result
//   is handed off is a one-cycle bubble: no product is accepted in it.
// =============================================================================
module mul_acc_stage #(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       n_terms,
    output logic             overflow
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (ACC_W < 6) begin : g_bad_acc_w
        $error("mul_acc_stage: ACC_W must be >= 6");
    end
    if (MAX_TERMS < 1 || MAX_TERMS > 255) begin : g_bad_max_terms
        $error("mul_acc_stage: MAX_TERMS must be in 1..255");
    end

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic ST_ACCUM = 1'b0;   // collecting products
    localparam logic ST_HOLD  = 1'b1;   // result presented downstream

    localparam logic [7:0] MAX_TERMS_L = 8'(MAX_TERMS);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic             r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_n_terms;
    logic             r_overflow;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    logic             w_accept;
    logic             w_release;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic [7:0]       w_n_next;
    logic             w_close;

    assign w_accept  = in_valid  && (r_state == ST_ACCUM);
    assign w_release = out_ready && (r_state == ST_HOLD);

    // Zero-extend the product to the one-bit-wider sum width. Built this way
    // so it stays legal when ACC_W == 6 (no zero-width replication).
    // NOTE: every variable assigned in always_comb gets a full default first
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_prod_ext      = '0;
        w_prod_ext[5:0] = prod;
    end

    // One extra bit on the adder captures the carry out of bit ACC_W-1.
    assign w_sum   = {1'b0, r_acc} + w_prod_ext;
    assign w_carry = w_sum[ACC_W];

`ifdef SATURATE_EN
    // Once the packet has overflowed, the accumulator stays pinned at full
    // scale even if a later product is zero and would produce no new carry.
    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_carry || r_overflow) begin
            w_acc_next = '1;
        end
    end
`else
    // Wrapping accumulator: plain modulo 2^ACC_W.
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    assign w_n_next = r_n_terms + 8'd1;

    // Packet closes on an explicit last flag or on reaching the term limit.
    assign w_close = in_last || (w_n_next == MAX_TERMS_L);

    // -------------------------------------------------------------------------
    // State and accumulator registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_n_terms  <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_n_terms  <= w_n_next;
            r_overflow <= r_overflow | w_carry;
            if (w_close) begin
                r_state <= ST_HOLD;
            end
        end else if (w_release) begin
            // Result taken: start a fresh packet next cycle. The handshake
            // cycle itself accepts nothing because in_ready is low in HOLD.
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_n_terms  <= '0;
            r_overflow <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: handshake flags are pure state decodes.
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign acc_out   = r_acc;
    assign n_terms   = r_n_terms;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_mul_acc_stage.sv
// =============================================================================
// tb_mul_acc_stage
// -----------------------------------------------------------------------------
// Directed bench for mul_acc_stage. Three instances share clock and reset:
//   u0 : ACC_W=12, MAX_TERMS=16  (basic packets, auto-close, hold, reset)
//   u1 : ACC_W=6,  MAX_TERMS=16  (wrap / saturate)
//   u2 : ACC_W=12, MAX_TERMS=1   (every accept closes the packet)
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, i.e. well away from the active edge.
// =============================================================================
module tb_mul_acc_stage;

    logic clk;
    logic rst_n;

    logic       iv   [3];
    logic       il   [3];
    logic       ordy [3];
    logic [5:0] pr   [3];

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [11:0] acc0;
    logic [5:0]  acc1;
    logic [11:0] acc2;
    logic [7:0]  nt0, nt1, nt2;
    logic        of0, of1, of2;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mul_acc_stage #(.ACC_W(12), .MAX_TERMS(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .prod(pr[0]),
        .in_last(il[0]), .out_valid(ov0), .out_ready(ordy[0]), .acc_out(acc0),
        .n_terms(nt0), .overflow(of0)
    );

    mul_acc_stage #(.ACC_W(6), .MAX_TERMS(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .prod(pr[1]),
        .in_last(il[1]), .out_valid(ov1), .out_ready(ordy[1]), .acc_out(acc1),
        .n_terms(nt1), .overflow(of1)
    );

    mul_acc_stage #(.ACC_W(12), .MAX_TERMS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .prod(pr[2]),
        .in_last(il[2]), .out_valid(ov2), .out_ready(ordy[2]), .acc_out(acc2),
        .n_terms(nt2), .overflow(of2)
    );

    // -------------------------------------------------------------------------
    // Per-instance output accessors
    // -------------------------------------------------------------------------
    function automatic logic [11:0] get_acc(int idx);
        case (idx)
            0:       return acc0;
            1:       return {6'd0, acc1};
            default: return acc2;
        endcase
    endfunction

    function automatic logic [7:0] get_nt(int idx);
        case (idx)
            0:       return nt0;
            1:       return nt1;
            default: return nt2;
        endcase
    endfunction

    function automatic logic get_ov(int idx);
        case (idx)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_ir(int idx);
        case (idx)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic get_of(int idx);
        case (idx)
            0:       return of0;
            1:       return of1;
            default: return of2;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Checking and stimulus tasks
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Full output snapshot against expected values.
    task automatic check_out(input string tag, input int idx, input logic exp_ov,
                             input logic exp_ir, input logic [11:0] exp_acc,
                             input logic [7:0] exp_nt, input logic exp_of);
        check({tag, ".out_valid"}, 32'(get_ov(idx)),  32'(exp_ov));
        check({tag, ".in_ready"},  32'(get_ir(idx)),  32'(exp_ir));
        check({tag, ".acc_out"},   32'(get_acc(idx)), 32'(exp_acc));
        check({tag, ".n_terms"},   32'(get_nt(idx)),  32'(exp_nt));
        check({tag, ".overflow"},  32'(get_of(idx)),  32'(exp_of));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product for exactly one cycle (caller ensures in_ready=1).
    task automatic send(input int idx, input logic [5:0] p, input logic last);
        iv[idx] = 1'b1;
        pr[idx] = p;
        il[idx] = last;
        tick();
        iv[idx] = 1'b0;
        il[idx] = 1'b0;
        pr[idx] = 6'h3f;   // garbage while not valid
    endtask

    task automatic take(input int idx);
        ordy[idx] = 1'b1;
        tick();
        ordy[idx] = 1'b0;
    endtask

    // Hard watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b0; pr[i] = 6'd0;
        end
        rst_n = 1'b0;
        #12;
        check_out("rst_low", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_out("rst_rel", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);

        // ---- 1: 1+2+3 with last on third ----
        send(0, 6'd1, 1'b0);
        send(0, 6'd2, 1'b0);
        check_out("t1_mid", 0, 1'b0, 1'b1, 12'd3, 8'd2, 1'b0);
        send(0, 6'd3, 1'b1);
        check_out("t1_res", 0, 1'b1, 1'b0, 12'd6, 8'd3, 1'b0);
        take(0);
        check_out("t1_clr", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);

        // Idle cycles with garbage prod/in_last: nothing changes.
        pr[0] = 6'd55; il[0] = 1'b1;
        tick(); tick();
        il[0] = 1'b0;
        check_out("idle", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);

        // ---- 2: 16 x 49 auto-closes at MAX_TERMS ----
        for (int i = 0; i < 16; i++) begin
            send(0, 6'd49, 1'b0);
            if (i == 14) check_out("t2_15", 0, 1'b0, 1'b1, 12'd735, 8'd15, 1'b0);
        end
        check_out("t2_res", 0, 1'b1, 1'b0, 12'd784, 8'd16, 1'b0);
        take(0);
        check_out("t2_clr", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);

        // ---- 3: ACC_W=6, 49+49 = 98 -> wrap 34 or saturate 63 ----
        send(1, 6'd49, 1'b0);
        check_out("t3_mid", 1, 1'b0, 1'b1, 12'd49, 8'd1, 1'b0);
        send(1, 6'd49, 1'b1);
`ifdef SATURATE_EN
        check_out("t3_res", 1, 1'b1, 1'b0, 12'd63, 8'd2, 1'b1);
`else
        check_out("t3_res", 1, 1'b1, 1'b0, 12'd34, 8'd2, 1'b1);
`endif
        take(1);
        check_out("t3_clr", 1, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);

        // ---- 4: hold under back-pressure, waiting product not lost ----
        send(0, 6'd7, 1'b1);
        iv[0] = 1'b1; pr[0] = 6'd9; il[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("t4_hold%0d", i), 0, 1'b1, 1'b0, 12'd7, 8'd1, 1'b0);
            tick();
        end
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check_out("t4_bubble", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);
        tick();
        iv[0] = 1'b0; il[0] = 1'b0;
        check_out("t4_next", 0, 1'b1, 1'b0, 12'd9, 8'd1, 1'b0);
        take(0);

        // ---- 5: async reset mid-packet ----
        send(0, 6'd10, 1'b0);
        send(0, 6'd20, 1'b0);
        check_out("t5_mid", 0, 1'b0, 1'b1, 12'd30, 8'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_out("t5_rst", 0, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(0, 6'd5, 1'b1);
        check_out("t5_new", 0, 1'b1, 1'b0, 12'd5, 8'd1, 1'b0);
        take(0);

        // ---- 6: MAX_TERMS=1, every accept closes ----
        send(2, 6'd13, 1'b0);
        check_out("t6_a", 2, 1'b1, 1'b0, 12'd13, 8'd1, 1'b0);
        take(2);
        check_out("t6_clr", 2, 1'b0, 1'b1, 12'd0, 8'd0, 1'b0);
        send(2, 6'd50, 1'b0);   // above the 3x3 range, still summed
        check_out("t6_b", 2, 1'b1, 1'b0, 12'd50, 8'd1, 1'b0);
        take(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
